// File: rtl/alu_cmp_pipe.sv
// ----------------------------------------------------------------------------
// alu_cmp_pipe
//   Two-stage pipelined compare/select unit with valid/ready flow control.
//   S1 registers the operands, op and tag on acceptance; S2 registers the
//   compare/select result, the {lt,eq,gt} flags and the tag. Outputs are
//   driven straight from the S2 registers. Full backpressure: a stalled S2
//   freezes its contents, and S1 only advances when S2 can take its entry.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   operation presented on a/b/op/in_tag
//   in_ready   unit accepts the operation this cycle
//   a, b       source operands (WIDTH bits)
//   op         op[3]=signed, op[2:0]=function (LT LE EQ GT GE NE MIN MAX)
//   in_tag     opaque tag returned with the result
//   out_valid  result/out_flags/out_tag are valid
//   out_ready  consumer takes the result this cycle
//   result     compare: zero-extended bit; MIN/MAX: selected operand
//   out_flags  {lt,eq,gt} of a vs b in the selected signedness
//   out_tag    tag of the operation
// ----------------------------------------------------------------------------
module alu_cmp_pipe #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [2:0]       out_flags,
    output logic [TAG_W-1:0] out_tag
);

    localparam logic [2:0] FN_LT  = 3'b000;
    localparam logic [2:0] FN_LE  = 3'b001;
    localparam logic [2:0] FN_EQ  = 3'b010;
    localparam logic [2:0] FN_GT  = 3'b011;
    localparam logic [2:0] FN_GE  = 3'b100;
    localparam logic [2:0] FN_NE  = 3'b101;
    localparam logic [2:0] FN_MIN = 3'b110;
    localparam logic [2:0] FN_MAX = 3'b111;

    logic             s1_valid_r;
    logic [WIDTH-1:0] s1_a_r;
    logic [WIDTH-1:0] s1_b_r;
    logic [3:0]       s1_op_r;
    logic [TAG_W-1:0] s1_tag_r;

    logic             s2_valid_r;
    logic [WIDTH-1:0] result_r;
    logic [2:0]       flags_r;
    logic [TAG_W-1:0] tag_r;

    logic             s1_en_s;
    logic             s2_en_s;
    logic [WIDTH-1:0] a_key_s;
    logic [WIDTH-1:0] b_key_s;
    logic             lt_s;
    logic             eq_s;
    logic             gt_s;
    logic             bit_s;
    logic [WIDTH-1:0] res_s;

    // Stage enables: a stage may load when it is empty or its content moves on.
    always_comb begin
        s2_en_s = !s2_valid_r || out_ready;
        s1_en_s = !s1_valid_r || s2_en_s;
    end

    assign in_ready  = s1_en_s;
    assign out_valid = s2_valid_r;
    assign result    = result_r;
    assign out_flags = flags_r;
    assign out_tag   = tag_r;

    // Compare keys: flipping the MSB maps two's complement order onto unsigned order.
    always_comb begin
        a_key_s = s1_a_r;
        b_key_s = s1_b_r;
        if (s1_op_r[3]) begin
            a_key_s[WIDTH-1] = ~s1_a_r[WIDTH-1];
            b_key_s[WIDTH-1] = ~s1_b_r[WIDTH-1];
        end else begin
            a_key_s = s1_a_r;
            b_key_s = s1_b_r;
        end
        eq_s = (s1_a_r == s1_b_r);
        lt_s = (a_key_s < b_key_s);
        gt_s = !lt_s && !eq_s;
    end

    // Function select: compare bit zero-extended, or MIN/MAX operand (ties give a).
    always_comb begin
        bit_s = 1'b0;
        res_s = {WIDTH{1'b0}};
        case (s1_op_r[2:0])
            FN_LT:   bit_s = lt_s;
            FN_LE:   bit_s = lt_s || eq_s;
            FN_EQ:   bit_s = eq_s;
            FN_GT:   bit_s = gt_s;
            FN_GE:   bit_s = gt_s || eq_s;
            FN_NE:   bit_s = !eq_s;
            FN_MIN:  bit_s = 1'b0;
            FN_MAX:  bit_s = 1'b0;
            default: bit_s = 1'b0;
        endcase
        case (s1_op_r[2:0])
            FN_MIN:  res_s = gt_s ? s1_b_r : s1_a_r;
            FN_MAX:  res_s = lt_s ? s1_b_r : s1_a_r;
            default: res_s = {{(WIDTH-1){1'b0}}, bit_s};
        endcase
    end

    // S1: operand/decode register, loads a new op on acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_a_r     <= {WIDTH{1'b0}};
            s1_b_r     <= {WIDTH{1'b0}};
            s1_op_r    <= 4'b0000;
            s1_tag_r   <= {TAG_W{1'b0}};
        end else if (s1_en_s) begin
            s1_valid_r <= in_valid;
            if (in_valid) begin
                s1_a_r   <= a;
                s1_b_r   <= b;
                s1_op_r  <= op;
                s1_tag_r <= in_tag;
            end
        end
    end

    // S2: result register; contents are frozen while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_r <= 1'b0;
            result_r   <= {WIDTH{1'b0}};
            flags_r    <= 3'b000;
            tag_r      <= {TAG_W{1'b0}};
        end else if (s2_en_s) begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                result_r <= res_s;
                flags_r  <= {lt_s, eq_s, gt_s};
                tag_r    <= s1_tag_r;
            end
        end
    end

endmodule
